// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit bridging the single-cycle core to a synchronous data RAM and an IO port.
// Ports: clk/rst (sync, active-low); core side i_mem_read, i_mem_write, i_addr, i_wdata, o_rdata, o_stall, o_fault;
// RAM side o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, i_ram_rdata; IO side o_io_req, o_io_we, o_io_addr,
// o_io_wdata, i_io_ack, i_io_rdata. Optional macro LSU_IO_TIMEOUT_EN adds an IO wait timeout of TIMEOUT cycles.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
`ifdef LSU_IO_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_stall,
    output logic              o_fault,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_io_req,
    output logic              o_io_we,
    output logic [7:0]        o_io_addr,
    output logic [31:0]       o_io_wdata,
    input  logic              i_io_ack,
    input  logic [31:0]       i_io_rdata
);
    typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_WAIT, IO_REQ, DONE} state_t;
    // One word-index register serves both the RAM address and the 8-bit IO index
    localparam int AW = ADDR_W > 8 ? ADDR_W : 8;
    state_t state_q, state_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic we_q, we_d, fault_q, fault_d;
    logic ram_en_q, ram_en_d, ram_we_q, ram_we_d, io_req_q, io_req_d;
    logic [2:0] cnt_q, cnt_d;
`ifdef LSU_IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_q, tmo_d;
`endif
    logic req, ram_hit, io_hit, bad;
    assign req     = i_mem_read | i_mem_write;
    assign ram_hit = i_addr[31:28] == 4'h0 && (i_addr[27:0] >> (ADDR_W + 2)) == 28'd0;
    assign io_hit  = i_addr[31:28] == 4'h1 && i_addr[27:10] == 18'd0;
    assign bad     = (|i_addr[1:0]) | ~(ram_hit | io_hit);
    assign o_stall     = state_q == IDLE ? req : state_q != DONE;
    assign o_rdata     = rdata_q;
    assign o_fault     = fault_q;
    assign o_ram_en    = ram_en_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_addr  = wa_q[ADDR_W-1:0];
    assign o_ram_wdata = wdata_q;
    assign o_io_req    = io_req_q;
    assign o_io_we     = we_q;
    assign o_io_addr   = wa_q[7:0];
    assign o_io_wdata  = wdata_q;
    always_comb begin
        state_d  = state_q;
        wa_d     = wa_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        io_req_d = 1'b0;
`ifdef LSU_IO_TIMEOUT_EN
        tmo_d    = '0;
`endif
        case (state_q)
            IDLE: if (req) begin
                wa_d     = i_addr[AW+1:2];
                wdata_d  = i_wdata;
                we_d     = i_mem_write;
                rdata_d  = '0;
                fault_d  = bad;
                // Strobes are registered on entry so they are clean for the whole access cycle
                ram_en_d = ~bad & ram_hit;
                ram_we_d = ~bad & ram_hit & i_mem_write;
                io_req_d = ~bad & io_hit;
                state_d  = bad ? DONE : ram_hit ? RAM_ACC : IO_REQ;
            end
            RAM_ACC: begin
                cnt_d   = 3'(RD_LAT - 1);
                state_d = we_q ? DONE : RAM_WAIT;
            end
            RAM_WAIT: if (cnt_q == 3'd0) begin
                rdata_d = i_ram_rdata;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            IO_REQ: if (i_io_ack) begin
                rdata_d = we_q ? 32'd0 : i_io_rdata;
                state_d = DONE;
`ifdef LSU_IO_TIMEOUT_EN
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                fault_d = 1'b1;
                state_d = DONE;
            end else begin
                io_req_d = 1'b1;
                tmo_d    = tmo_q + 1'b1;
            end
`else
            end else begin
                io_req_d = 1'b1;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wa_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            io_req_q <= 1'b0;
`ifdef LSU_IO_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wa_q     <= wa_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
            io_req_q <= io_req_d;
`ifdef LSU_IO_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl with RD_LAT=1 and RD_LAT=3 instances.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    logic rst, rd, wr, io_ack;
    logic [31:0] addr, wdata, io_rdata, ram_rdata;
    logic [31:0] rdata, ram_wdata, io_wdata;
    logic stall, fault, ram_en, ram_we, io_req, io_we;
    logic [9:0] ram_addr;
    logic [7:0] io_addr;
    logic b_rst, b_rd;
    logic [31:0] b_addr, b_ram_rdata, b_rdata, b_ram_wdata, b_io_wdata, p1, p2;
    logic b_stall, b_fault, b_ram_en, b_ram_we, b_io_req, b_io_we;
    logic [9:0] b_ram_addr;
    logic [7:0] b_io_addr;
    logic [31:0] mem [0:1023];
    int nen = 0, nwr = 0, nio = 0;
    logic [9:0] lw_addr;
    logic [31:0] lw_data;
    lsu_mem_ctrl #(.ADDR_W(10), .RD_LAT(1)
`ifdef LSU_IO_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) u1 (
        .clk(clk), .rst(rst), .i_mem_read(rd), .i_mem_write(wr), .i_addr(addr), .i_wdata(wdata),
        .o_rdata(rdata), .o_stall(stall), .o_fault(fault), .o_ram_en(ram_en), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_io_req(io_req),
        .o_io_we(io_we), .o_io_addr(io_addr), .o_io_wdata(io_wdata), .i_io_ack(io_ack), .i_io_rdata(io_rdata)
    );
    lsu_mem_ctrl #(.ADDR_W(10), .RD_LAT(3)
`ifdef LSU_IO_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) u3 (
        .clk(clk), .rst(b_rst), .i_mem_read(b_rd), .i_mem_write(1'b0), .i_addr(b_addr), .i_wdata(32'd0),
        .o_rdata(b_rdata), .o_stall(b_stall), .o_fault(b_fault), .o_ram_en(b_ram_en), .o_ram_we(b_ram_we),
        .o_ram_addr(b_ram_addr), .o_ram_wdata(b_ram_wdata), .i_ram_rdata(b_ram_rdata), .o_io_req(b_io_req),
        .o_io_we(b_io_we), .o_io_addr(b_io_addr), .o_io_wdata(b_io_wdata), .i_io_ack(1'b0), .i_io_rdata(32'd0)
    );
    always @(posedge clk) begin
        if (ram_en) nen <= nen + 1;
        if (io_req) nio <= nio + 1;
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            nwr <= nwr + 1;
            lw_addr <= ram_addr;
            lw_data <= ram_wdata;
        end
        ram_rdata <= (ram_en && !ram_we) ? mem[ram_addr] : 32'd0;
        p1 <= (b_ram_en && !b_ram_we && b_ram_addr == 10'd5) ? 32'h1357_9BDF : 32'd0;
        p2 <= p1;
        b_ram_rdata <= p2;
    end
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int sc, output logic [31:0] rv, output logic fv);
        rd = r; wr = w; addr = a; wdata = d; sc = 0;
        #1;
        while (stall && sc < 300) begin
            sc++;
            @(negedge clk);
        end
        rv = rdata; fv = fault;
        rd = 0; wr = 0;
        @(negedge clk);
    endtask
    task automatic test_reset();
        rst = 0; rd = 0; wr = 0; addr = 0; wdata = 0; io_ack = 0; io_rdata = 0;
        b_rst = 0; b_rd = 0; b_addr = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdata, stall, fault, ram_en, ram_we, ram_addr, ram_wdata, io_req, io_we, io_addr, io_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: stall=%b ram_en=%b io_req=%b rdata=%h, required all zero", stall, ram_en, io_req, rdata);
        end
        checks++;
        if ({b_rdata, b_stall, b_fault, b_ram_en, b_io_req, b_ram_addr} !== '0) begin
            errors++; $display("FAIL reset_outputs_lat3: stall=%b ram_en=%b rdata=%h, required all zero", b_stall, b_ram_en, b_rdata);
        end
        rst = 1; b_rst = 1;
        @(negedge clk);
        wr = 1; addr = 32'h30; wdata = 32'h1111_1111; rst = 0;
        @(negedge clk);
        wr = 0; rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL reset_abandon_state: stall=%b ram_en=%b, required 0 0", stall, ram_en);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (nwr !== 0) begin
            errors++; $display("FAIL reset_abandon_write: ram writes=%0d, required 0", nwr);
        end
    endtask
    task automatic test_ram_store_load();
        int sc, n0;
        logic [31:0] rv;
        logic fv;
        n0 = nwr;
        access(0, 1, 32'h10, 32'hDEAD_BEEF, sc, rv, fv);
        checks++;
        if (sc !== 2 || {rv, fv} !== 33'd0) begin
            errors++; $display("FAIL store_stall: stall=%0d rdata=%h fault=%b, required 2 0 0", sc, rv, fv);
        end
        checks++;
        if (nwr !== n0 + 1 || lw_addr !== 10'd4 || lw_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_ram: writes=%0d addr=%0d data=%h, required %0d 4 deadbeef", nwr - n0, lw_addr, lw_data, 1);
        end
        access(1, 0, 32'h10, 32'h0, sc, rv, fv);
        checks++;
        if (sc !== 3 || rv !== 32'hDEAD_BEEF || fv !== 1'b0) begin
            errors++; $display("FAIL load: stall=%0d rdata=%h fault=%b, required 3 deadbeef 0", sc, rv, fv);
        end
        access(0, 1, 32'hFFC, 32'h600D_CAFE, sc, rv, fv);
        checks++;
        if (lw_addr !== 10'd1023 || fv !== 1'b0) begin
            errors++; $display("FAIL top_word_store: addr=%0d fault=%b, required 1023 0", lw_addr, fv);
        end
        access(1, 0, 32'hFFC, 32'h0, sc, rv, fv);
        checks++;
        if (sc !== 3 || rv !== 32'h600D_CAFE || fv !== 1'b0) begin
            errors++; $display("FAIL top_word_load: stall=%0d rdata=%h fault=%b, required 3 600dcafe 0", sc, rv, fv);
        end
    endtask
    task automatic test_faults();
        int sc, e0, w0, i0;
        logic [31:0] rv;
        logic fv;
        logic [31:0] fa [5];
        fa = '{32'h12, 32'h1000, 32'h2000_0000, 32'h1000_0400, 32'h11};
        e0 = nen; w0 = nwr; i0 = nio;
        access(1, 0, 32'hAAAA_0000 | 32'h0, 32'h0, sc, rv, fv);
        checks++;
        if (sc !== 1 || fv !== 1'b1 || rv !== 32'd0) begin
            errors++; $display("FAIL fault_unmapped: stall=%0d fault=%b rdata=%h, required 1 1 0", sc, fv, rv);
        end
        for (int i = 0; i < 5; i++) begin
            access(1'(i % 2 == 0), 1'(i % 2 == 1), fa[i], 32'h5A5A_5A5A, sc, rv, fv);
            checks++;
            if (sc !== 1 || fv !== 1'b1 || rv !== 32'd0) begin
                errors++; $display("FAIL fault_%0h: stall=%0d fault=%b rdata=%h, required 1 1 0", fa[i], sc, fv, rv);
            end
        end
        checks++;
        if (nen !== e0 || nwr !== w0 || nio !== i0) begin
            errors++; $display("FAIL fault_no_strobe: ram_en=%0d io_req=%0d cycles, required 0 0", nen - e0, nio - i0);
        end
    endtask
    task automatic test_io();
        int hi, cyc;
        io_ack = 1; io_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        io_ack = 0; io_rdata = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || io_req !== 1'b0) begin
            errors++; $display("FAIL stray_ack: stall=%b io_req=%b, required 0 0", stall, io_req);
        end
        @(negedge clk);
        rd = 1; addr = 32'h1000_0008;
        @(negedge clk);
        checks++;
        if (io_req !== 1'b1 || io_addr !== 8'd2 || io_we !== 1'b0) begin
            errors++; $display("FAIL io_read_req: req=%b addr=%0d we=%b, required 1 2 0", io_req, io_addr, io_we);
        end
        hi = 0; cyc = 0;
        while (stall && cyc < 50) begin
            if (io_req) hi++;
            if (hi == 3) begin io_ack = 1; io_rdata = 32'h55; end
            @(negedge clk);
            io_ack = 0; io_rdata = 0; cyc++;
        end
        checks++;
        if (hi !== 3 || stall !== 1'b0 || rdata !== 32'h55 || fault !== 1'b0 || io_req !== 1'b0) begin
            errors++; $display("FAIL io_read: req_cycles=%0d stall=%b rdata=%h fault=%b, required 3 0 55 0", hi, stall, rdata, fault);
        end
        rd = 0;
        @(negedge clk);
        wr = 1; addr = 32'h1000_0010; wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (io_req !== 1'b1 || io_we !== 1'b1 || io_addr !== 8'd4 || io_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL io_write_req: req=%b we=%b addr=%0d wdata=%h, required 1 1 4 12345678", io_req, io_we, io_addr, io_wdata);
        end
        io_ack = 1; io_rdata = 32'hABCD;
        @(negedge clk);
        io_ack = 0; io_rdata = 0;
        checks++;
        if (stall !== 1'b0 || rdata !== 32'd0 || fault !== 1'b0 || io_req !== 1'b0) begin
            errors++; $display("FAIL io_write_done: stall=%b rdata=%h fault=%b req=%b, required 0 0 0 0", stall, rdata, fault, io_req);
        end
        wr = 0;
        @(negedge clk);
    endtask
    task automatic test_io_timeout();
        int hi, cyc;
`ifdef LSU_IO_TIMEOUT_EN
        rd = 1; addr = 32'h1000_0004;
        @(negedge clk);
        hi = 0; cyc = 0;
        while (stall && cyc < 50) begin
            if (io_req) hi++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (hi !== 4 || stall !== 1'b0 || fault !== 1'b1 || rdata !== 32'd0) begin
            errors++; $display("FAIL io_timeout: req_cycles=%0d stall=%b fault=%b rdata=%h, required 4 0 1 0", hi, stall, fault, rdata);
        end
        rd = 0;
        @(negedge clk);
        rd = 1;
        repeat (4) @(negedge clk);
        io_ack = 1; io_rdata = 32'h77;
        @(negedge clk);
        io_ack = 0; io_rdata = 0;
        checks++;
        if (stall !== 1'b0 || fault !== 1'b0 || rdata !== 32'h77) begin
            errors++; $display("FAIL io_ack_at_timeout: stall=%b fault=%b rdata=%h, required 0 0 77", stall, fault, rdata);
        end
        rd = 0;
        @(negedge clk);
`else
        rd = 1; addr = 32'h1000_0004;
        hi = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (stall && io_req) hi++;
        end
        checks++;
        if (hi !== 120) begin
            errors++; $display("FAIL io_wait_forever: stalled cycles=%0d, required 120", hi);
        end
        cyc = 0;
        rst = 0; rd = 0;
        @(negedge clk);
        rst = 1;
        checks++;
        if ({stall, io_req, fault, rdata} !== '0) begin
            errors++; $display("FAIL io_wait_reset: stall=%b io_req=%b fault=%b, required 0 0 0", stall, io_req, fault);
        end
        @(negedge clk);
`endif
    endtask
    task automatic test_back_to_back();
        int sc, w0;
        logic [31:0] rv;
        logic fv;
        access(0, 1, 32'h20, 32'hCAFE_F00D, sc, rv, fv);
        access(1, 0, 32'h20, 32'h0, sc, rv, fv);
        checks++;
        if (sc !== 3 || rv !== 32'hCAFE_F00D || fv !== 1'b0) begin
            errors++; $display("FAIL b2b_load: stall=%0d rdata=%h fault=%b, required 3 cafef00d 0", sc, rv, fv);
        end
        w0 = nwr;
        access(1, 1, 32'h24, 32'h0BAD_F00D, sc, rv, fv);
        checks++;
        if (sc !== 2 || nwr !== w0 + 1 || rv !== 32'd0 || fv !== 1'b0) begin
            errors++; $display("FAIL both_high_write: stall=%0d writes=%0d rdata=%h, required 2 1 0", sc, nwr - w0, rv);
        end
        access(1, 0, 32'h24, 32'h0, sc, rv, fv);
        checks++;
        if (sc !== 3 || rv !== 32'h0BAD_F00D || nwr !== w0 + 1) begin
            errors++; $display("FAIL both_high_readback: stall=%0d rdata=%h, required 3 0badf00d", sc, rv);
        end
    endtask
    task automatic test_reset_mid_read();
        int sc;
        b_rd = 1; b_addr = 32'h14;
        @(negedge clk);
        checks++;
        if (b_ram_en !== 1'b1 || b_ram_we !== 1'b0 || b_ram_addr !== 10'd5) begin
            errors++; $display("FAIL lat3_ram_acc: en=%b we=%b addr=%0d, required 1 0 5", b_ram_en, b_ram_we, b_ram_addr);
        end
        repeat (2) @(negedge clk);
        b_rst = 0; b_rd = 0;
        @(negedge clk);
        checks++;
        if ({b_rdata, b_stall, b_fault, b_ram_en, b_ram_we, b_ram_addr, b_io_req, b_io_we, b_io_addr} !== '0) begin
            errors++; $display("FAIL reset_mid_read: stall=%b en=%b addr=%0d rdata=%h, required all zero", b_stall, b_ram_en, b_ram_addr, b_rdata);
        end
        b_rst = 1;
        @(negedge clk);
        b_rd = 1; sc = 0;
        #1;
        while (b_stall && sc < 50) begin
            sc++;
            @(negedge clk);
        end
        checks++;
        if (sc !== 5 || b_rdata !== 32'h1357_9BDF || b_fault !== 1'b0) begin
            errors++; $display("FAIL lat3_load_after_reset: stall=%0d rdata=%h fault=%b, required 5 13579bdf 0", sc, b_rdata, b_fault);
        end
        b_rd = 0;
        @(negedge clk);
    endtask
    initial begin
        test_reset();
        test_ram_store_load();
        test_faults();
        test_io();
        test_io_timeout();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
